mem_rd_streamer: RTL and testbench

//   Streams DATA_SIZE consecutive words from an external read-only RAM port into a

---
 rtl/mem_rd_streamer_pkg.sv | 8 +
 rtl/mem_rd_streamer_rd_valid_pipe.sv | 19 +
 rtl/mem_rd_streamer.sv | 79 +++++++
 tb/tb_mem_rd_streamer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mem_rd_streamer_pkg.sv
// mem_rd_streamer_pkg: shared state encoding and default widths/latency for the RAM streamers
package mem_rd_streamer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int DEF_AW = 16;
  localparam int DEF_DW = 32;
  localparam int DEF_CW = 16;
  localparam int DEF_RD_LATENCY = 2;
endpackage

// File: rtl/mem_rd_streamer_rd_valid_pipe.sv
// mem_rd_streamer_rd_valid_pipe: LAT-deep valid shift register tracking outstanding RAM reads
module mem_rd_streamer_rd_valid_pipe #(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  output logic tail,
  output logic any_valid
);
  logic [LAT-1:0] q;
  logic [LAT:0] sh;
  assign sh = {q, issue};
  assign tail = q[LAT-1];
  assign any_valid = |q;
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else q <= sh[LAT-1:0];
endmodule

// File: rtl/mem_rd_streamer.sv
// mem_rd_streamer: streams DATA_SIZE RAM words into a FIFO; MEM_RD_STREAMER_BASE_ADDR_EN adds a base_addr input
module mem_rd_streamer
  import mem_rd_streamer_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int CW = DEF_CW,
  parameter int DATA_SIZE = 256,
  parameter int RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          done,
  output logic          busy,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] data_from_ram,
  output logic          fifo_push,
  output logic [DW-1:0] data_to_fifo,
  input  logic          fifo_almost_full
`ifdef MEM_RD_STREAMER_BASE_ADDR_EN
  ,
  input  logic [AW-1:0] base_addr
`endif
);
  localparam logic [CW-1:0] N = CW'(DATA_SIZE);
  localparam logic [CW-1:0] LAST = CW'(DATA_SIZE - 1);
  state_t state, state_nx;
  logic [CW-1:0] issue_cnt, push_cnt;
  logic [AW-1:0] start_addr;
  logic accept, issue, any_valid, last_push, drained;
`ifdef MEM_RD_STREAMER_BASE_ADDR_EN
  assign start_addr = base_addr;
`else
  assign start_addr = '0;
`endif
  assign accept = state == IDLE && start;
  assign issue = state == RUN && !fifo_almost_full && issue_cnt < N;
  assign last_push = fifo_push && push_cnt == LAST;
  assign drained = !any_valid && push_cnt == N;
  assign data_to_fifo = data_from_ram;
  assign busy = state == RUN || state == DRAIN;
  assign done = state == DONE;
  // Leave for DONE on the final push itself so done lands exactly one cycle after it
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE  ? (start ? RUN : IDLE)
             : state == RUN   ? (issue_cnt == N ? (last_push ? DONE : DRAIN) : RUN)
             : state == DRAIN ? (last_push || drained ? DONE : DRAIN)
             : IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      ram_addr <= '0;
      issue_cnt <= '0;
      push_cnt <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        ram_addr <= start_addr;
        issue_cnt <= '0;
        push_cnt <= '0;
      end else begin
        if (issue) begin
          ram_addr <= ram_addr + 1'b1;
          issue_cnt <= issue_cnt + 1'b1;
        end
        if (fifo_push) push_cnt <= push_cnt + 1'b1;
      end
    end
  mem_rd_streamer_rd_valid_pipe #(.LAT(RD_LATENCY)) u_pipe (
    .clk(clk),
    .rst(rst),
    .issue(issue),
    .tail(fifo_push),
    .any_valid(any_valid)
  );
endmodule

// File: tb/tb_mem_rd_streamer.sv
// tb_mem_rd_streamer: scoreboard bench for three streamer instances (16, 1 and 1024 words)
module tb_mem_rd_streamer;
  logic clk = 0, rst = 1;
  logic start [3];
  logic af [3];
  logic done [3], busy [3], push [3];
  logic [15:0] addr [3], base [3];
  logic [31:0] din [3], dout [3], p1 [3];
  logic [31:0] q0 [$], q1 [$], q2 [$];
  int total = 0, bad = 0;
  int pc [3];

  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [15:0] a);
    return {a ^ 16'hA5C3, a};
  endfunction

  always @(posedge clk)
    for (int i = 0; i < 3; i++) begin
      p1[i] <= f(addr[i]);
      din[i] <= p1[i];
    end

  mem_rd_streamer #(.DATA_SIZE(16)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .done(done[0]), .busy(busy[0]),
    .ram_addr(addr[0]), .data_from_ram(din[0]), .fifo_push(push[0]),
    .data_to_fifo(dout[0]), .fifo_almost_full(af[0])
`ifdef MEM_RD_STREAMER_BASE_ADDR_EN
    , .base_addr(base[0])
`endif
  );
  mem_rd_streamer #(.DATA_SIZE(1)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .done(done[1]), .busy(busy[1]),
    .ram_addr(addr[1]), .data_from_ram(din[1]), .fifo_push(push[1]),
    .data_to_fifo(dout[1]), .fifo_almost_full(af[1])
`ifdef MEM_RD_STREAMER_BASE_ADDR_EN
    , .base_addr(base[1])
`endif
  );
  mem_rd_streamer #(.DATA_SIZE(1024)) u2 (
    .clk(clk), .rst(rst), .start(start[2]), .done(done[2]), .busy(busy[2]),
    .ram_addr(addr[2]), .data_from_ram(din[2]), .fifo_push(push[2]),
    .data_to_fifo(dout[2]), .fifo_almost_full(af[2])
`ifdef MEM_RD_STREAMER_BASE_ADDR_EN
    , .base_addr(base[2])
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic mon(input int i, input logic [31:0] got, input bit have, input logic [31:0] exp);
    total++;
    pc[i]++;
    if (!have) begin
      bad++;
      $display("FAIL push%0d unexpected got=%h want=none t=%0t", i, got, $time);
    end else if (got !== exp) begin
      bad++;
      $display("FAIL push%0d data got=%h want=%h t=%0t", i, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit h;
    logic [31:0] e;
    if (push[0]) begin h = q0.size() != 0; e = h ? q0.pop_front() : '0; mon(0, dout[0], h, e); end
    if (push[1]) begin h = q1.size() != 0; e = h ? q1.pop_front() : '0; mon(1, dout[1], h, e); end
    if (push[2]) begin h = q2.size() != 0; e = h ? q2.pop_front() : '0; mon(2, dout[2], h, e); end
  end

  task automatic xfer(input logic [15:0] b, input int af_lo, input int af_hi, input int st2, input bit exact);
    int dn = 0, afp = 0, p0;
    for (int i = 0; i < 16; i++) q0.push_back(f(b + 16'(i)));
    base[0] = b;
    start[0] = 1;
    @(posedge clk); #1;
    start[0] = 0;
    p0 = pc[0];
    for (int k = 1; k <= 40; k++) begin
      af[0] = k >= af_lo && k <= af_hi;
      start[0] = k == st2;
      if (exact) begin
        if (k <= 16) chk("addr", addr[0], b + 16'(k - 1));
        chk("push_t", push[0], k >= 3 && k <= 18);
        chk("done_t", done[0], k == 19);
        chk("busy_t", busy[0], k <= 18);
      end
      if (af_lo > 0 && k >= af_lo && k <= af_hi + 1) chk("af_hold", addr[0], b + 16'(af_lo - 1));
      if (af[0] && push[0]) afp++;
      if (done[0]) dn++;
      @(posedge clk); #1;
    end
    af[0] = 0;
    start[0] = 0;
    chk("done_count", dn, 1);
    chk("push_count", pc[0] - p0, 16);
    chk("sb_empty", q0.size(), 0);
    if (af_lo > 0) chk("af_pushes_le2", afp <= 2, 1);
  endtask

  initial begin
    int n, p;
    for (int i = 0; i < 3; i++) begin start[i] = 0; af[i] = 0; base[i] = 0; pc[i] = 0; end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_addr", addr[i], 0);
      chk("rst_busy", busy[i], 0);
      chk("rst_done", done[i], 0);
      chk("rst_push", push[i], 0);
    end
    rst = 0;
    @(posedge clk); #1;
    xfer(16'h0000, 0, 0, 0, 1);
    xfer(16'h0000, 5, 9, 0, 0);
    xfer(16'h0000, 0, 0, 7, 1);
    xfer(16'h0000, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) q0.push_back(f(16'(i)));
    start[0] = 1;
    @(posedge clk); #1;
    start[0] = 0;
    for (int k = 1; k < 10; k++) begin @(posedge clk); #1; end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    q0.delete();
    chk("mid_rst_addr", addr[0], 0);
    chk("mid_rst_push", push[0], 0);
    chk("mid_rst_done", done[0], 0);
    chk("mid_rst_busy", busy[0], 0);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      if (push[0] || done[0] || busy[0]) n++;
      @(posedge clk); #1;
    end
    chk("post_rst_quiet", n, 0);
    xfer(16'h0000, 0, 0, 0, 1);
    q1.push_back(f(16'h0000));
    start[1] = 1;
    @(posedge clk); #1;
    start[1] = 0;
    for (int k = 1; k <= 6; k++) begin
      if (k == 1) chk("n1_addr", addr[1], 0);
      chk("n1_push", push[1], k == 3);
      chk("n1_done", done[1], k == 4);
      @(posedge clk); #1;
    end
    chk("n1_count", pc[1], 1);
    for (int i = 0; i < 1024; i++) q2.push_back(f(16'(i)));
    start[2] = 1;
    @(posedge clk); #1;
    start[2] = 0;
    p = pc[2];
    n = 0;
    while (!done[2] && n < 5000) begin
      af[2] = $urandom_range(0, 3) == 0;
      @(posedge clk); #1;
      n++;
    end
    af[2] = 0;
    chk("big_done_seen", n < 5000, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("big_count", pc[2] - p, 1024);
    chk("big_sb_empty", q2.size(), 0);
`ifdef MEM_RD_STREAMER_BASE_ADDR_EN
    xfer(16'hFFFE, 0, 0, 0, 1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
